// File: rtl/uart_frame_tx.sv
// Packet framer feeding a UART transmitter: sends HEADER, the payload bytes
// (least-significant first) and an XOR checksum, pacing on tx_done_tick.
module uart_frame_tx #(
   parameter int         N_BYTES = 3,
   parameter logic [7:0] HEADER  = 8'hA5,
   parameter int         TIMEOUT = 200_000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pkt_valid,
   input  logic [8*N_BYTES-1:0] pkt_data,
   output logic                 pkt_ready,
   output logic                 busy,
   output logic                 pkt_done,
   output logic                 err,
   output logic                 tx_start,
   output logic [7:0]           tx_din,
   input  logic                 tx_done_tick
);

   localparam int IDX_W = $clog2(N_BYTES + 2);
   localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BYTES + 1);
   localparam logic [IDX_W-1:0] IDX_LASTPAY = IDX_W'(N_BYTES);
   localparam logic [WD_W-1:0]  WD_TOP = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t                 state_reg, state_next;
   logic [IDX_W-1:0]       idx_reg, idx_next;
   logic [WD_W-1:0]        wd_reg, wd_next;
   logic [8*N_BYTES-1:0]   data_reg, data_next;
   logic [7:0]             csum_reg, csum_next;

   logic                   pkt_ready_reg, pkt_ready_next;
   logic                   busy_reg, busy_next;
   logic                   pkt_done_reg, pkt_done_next;
   logic                   err_reg, err_next;
   logic                   tx_start_reg, tx_start_next;
   logic [7:0]             tx_din_reg, tx_din_next;

   logic [7:0]             payload [N_BYTES];
   logic [7:0]             next_payload;

   genvar gi;
   generate
      for (gi = 0; gi < N_BYTES; gi++) begin : g_payload
         assign payload[gi] = data_reg[8*gi +: 8];
      end
   endgenerate

   // Payload byte that follows the one just completed: idx_reg counts
   // header as 0, so payload[idx_reg] is the byte for index idx_reg+1.
   always_comb begin
      next_payload = 8'h00;
      for (int i = 0; i < N_BYTES; i++) begin
         if (idx_reg == IDX_W'(i)) begin
            next_payload = payload[i];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         wd_reg        <= '0;
         data_reg      <= '0;
         csum_reg      <= 8'h00;
         pkt_ready_reg <= 1'b1;
         busy_reg      <= 1'b0;
         pkt_done_reg  <= 1'b0;
         err_reg       <= 1'b0;
         tx_start_reg  <= 1'b0;
         tx_din_reg    <= 8'h00;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         wd_reg        <= wd_next;
         data_reg      <= data_next;
         csum_reg      <= csum_next;
         pkt_ready_reg <= pkt_ready_next;
         busy_reg      <= busy_next;
         pkt_done_reg  <= pkt_done_next;
         err_reg       <= err_next;
         tx_start_reg  <= tx_start_next;
         tx_din_reg    <= tx_din_next;
      end
   end

   // Outputs are registered, so the byte and start pulse for a SEND cycle
   // are prepared on the transition into SEND.
   always_comb begin
      state_next    = state_reg;
      idx_next      = idx_reg;
      wd_next       = wd_reg;
      data_next     = data_reg;
      csum_next     = csum_reg;
      pkt_done_next = 1'b0;
      err_next      = 1'b0;
      tx_start_next = 1'b0;
      tx_din_next   = tx_din_reg;

      case (state_reg)
         IDLE: begin
            if (pkt_valid && pkt_ready_reg) begin
               data_next     = pkt_data;
               csum_next     = HEADER;
               idx_next      = '0;
               tx_din_next   = HEADER;
               tx_start_next = 1'b1;
               state_next    = SEND;
            end
         end

         SEND: begin
            wd_next    = '0;
            state_next = WAIT;
         end

         WAIT: begin
            if (tx_done_tick) begin
               if (idx_reg == IDX_LAST) begin
                  pkt_done_next = 1'b1;
                  wd_next       = '0;
                  state_next    = IDLE;
               end else begin
                  idx_next      = idx_reg + IDX_W'(1);
                  tx_start_next = 1'b1;
                  state_next    = SEND;
                  if (idx_reg == IDX_LASTPAY) begin
                     tx_din_next = csum_reg;
                  end else begin
                     tx_din_next = next_payload;
                     csum_next   = csum_reg ^ next_payload;
                  end
               end
            end else if ((TIMEOUT != 0) && (wd_reg == WD_TOP)) begin
               err_next   = 1'b1;
               wd_next    = '0;
               state_next = IDLE;
            end else begin
               wd_next = wd_reg + WD_W'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next      = (state_next != IDLE);
      pkt_ready_next = (state_next == IDLE);
   end

   assign pkt_ready = pkt_ready_reg;
   assign busy      = busy_reg;
   assign pkt_done  = pkt_done_reg;
   assign err       = err_reg;
   assign tx_start  = tx_start_reg;
   assign tx_din    = tx_din_reg;

endmodule
